sdram_burst_reader: RTL

Bus-master read DMA that sits directly upstream of the SDRAM controller on the shared system bus. Given a base address and word count, it requests the bus, issues read bursts to SDRAM, and buffers the returned 32-bit words in an internal FIFO for a streaming consumer such as the pixel or camera path. Bursts are issued only when the FIFO can absorb the whole burst, so the block never stalls the bus.

---
 rtl/sdram_burst_reader.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/sdram_burst_reader.sv
// sdram_burst_reader: bus-master read DMA feeding a first-word-fall-through FIFO.
// A burst is requested only once the FIFO has room for all of it, so the
// block never has to stall the slave mid-burst.
module sdram_burst_reader #(
    parameter int FIFO_DEPTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                            systemClock,
    input  logic                            systemResetN,
    input  logic                            startIn,
    input  logic [31:0]                     baseAddressIn,
    input  logic [15:0]                     wordCountIn,
    output logic                            activeOut,
    output logic                            doneOut,
    output logic                            errorOut,
    output logic                            requestBusOut,
    input  logic                            busGrantIn,
    output logic                            beginTransactionOut,
    output logic [31:0]                     addressDataOut,
    output logic [3:0]                      byteEnablesOut,
    output logic                            readNotWriteOut,
    output logic [7:0]                      burstSizeOut,
    input  logic [31:0]                     addressDataIn,
    input  logic                            dataValidIn,
    input  logic                            endTransactionIn,
    input  logic                            busErrorIn,
    input  logic                            fifoPopIn,
    output logic [31:0]                     fifoDataOut,
    output logic                            fifoEmptyOut,
    output logic [$clog2(FIFO_DEPTH):0]     fifoLevelOut
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] ONE_P = 1;
    localparam logic [LW-1:0] ONE_L = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_REQ, S_BEGIN, S_DATA, S_FINISH, S_ERROR
    } state_t;

    state_t        r_state;
    logic [31:0]   r_addr;
    logic [15:0]   r_remain;
    logic [8:0]    r_len;
    logic [8:0]    r_rcv;
    logic [15:0]   r_tmo;

    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;

    logic          w_push;
    logic          w_pop;
    logic [8:0]    w_len;
    logic [16:0]   w_free;
    logic          w_space_ok;
    logic [8:0]    w_rcv_now;
    logic [15:0]   w_remain_next;
    logic          w_tmo_hit;

    // Burst sizing, free-space check and end-of-burst bookkeeping
    always_comb begin
        w_push        = (r_state == S_DATA) && dataValidIn && !busErrorIn;
        w_pop         = fifoPopIn && (r_level != '0);
        w_len         = (r_remain > 16'(MAX_BURST)) ? 9'(MAX_BURST) : r_remain[8:0];
        // a pop in this cycle already counts as free space
        w_free        = 17'(FIFO_DEPTH) - 17'(r_level) + 17'(w_pop);
        w_space_ok    = w_free >= 17'(w_len);
        w_rcv_now     = r_rcv + 9'(dataValidIn);
        w_remain_next = (16'(w_rcv_now) >= r_remain) ? 16'd0 : r_remain - 16'(w_rcv_now);
        w_tmo_hit     = r_tmo == 16'(TIMEOUT);
    end

    // Transfer FSM with registered bus and status outputs
    always_ff @(posedge systemClock or negedge systemResetN) begin
        if (!systemResetN) begin
            r_state             <= S_IDLE;
            r_addr              <= '0;
            r_remain            <= '0;
            r_len               <= '0;
            r_rcv               <= '0;
            r_tmo               <= '0;
            activeOut           <= 1'b0;
            doneOut             <= 1'b0;
            errorOut            <= 1'b0;
            requestBusOut       <= 1'b0;
            beginTransactionOut <= 1'b0;
            addressDataOut      <= '0;
            byteEnablesOut      <= '0;
            readNotWriteOut     <= 1'b0;
            burstSizeOut        <= '0;
        end else begin
            doneOut             <= 1'b0;
            beginTransactionOut <= 1'b0;
            addressDataOut      <= '0;
            byteEnablesOut      <= '0;
            readNotWriteOut     <= 1'b0;
            burstSizeOut        <= '0;
            case (r_state)
                S_IDLE: begin
                    if (startIn) begin
                        errorOut <= 1'b0;
                        if (wordCountIn != 16'd0) begin
                            r_addr    <= baseAddressIn;
                            r_remain  <= wordCountIn;
                            activeOut <= 1'b1;
                            r_state   <= S_WAIT;
                        end else begin
                            doneOut <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_space_ok) begin
                        r_len         <= w_len;
                        requestBusOut <= 1'b1;
                        r_state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (busGrantIn) begin
                        beginTransactionOut <= 1'b1;
                        addressDataOut      <= r_addr;
                        byteEnablesOut      <= 4'hF;
                        readNotWriteOut     <= 1'b1;
                        burstSizeOut        <= 8'(r_len - 9'd1);
                        r_rcv               <= '0;
                        // timeout counts cycles from the begin strobe onward
                        r_tmo               <= '0;
                        r_state             <= S_BEGIN;
                    end
                end
                S_BEGIN: begin
                    r_tmo   <= r_tmo + 16'd1;
                    r_state <= S_DATA;
                end
                S_DATA: begin
                    r_tmo <= r_tmo + 16'd1;
                    if (dataValidIn) r_rcv <= w_rcv_now;
                    if (busErrorIn || w_tmo_hit) begin
                        errorOut      <= 1'b1;
                        requestBusOut <= 1'b0;
                        activeOut     <= 1'b0;
                        r_state       <= S_ERROR;
                    end else if (endTransactionIn) begin
                        r_remain      <= w_remain_next;
                        r_addr        <= r_addr + {21'd0, r_len, 2'b00};
                        requestBusOut <= 1'b0;
                        if (w_remain_next == 16'd0) begin
                            doneOut   <= 1'b1;
                            activeOut <= 1'b0;
                            r_state   <= S_FINISH;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_FINISH: r_state <= S_IDLE;
                S_ERROR:  r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers and fill level
    always_ff @(posedge systemClock or negedge systemResetN) begin
        if (!systemResetN) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + ONE_P;
            if (w_pop)  r_rptr <= r_rptr + ONE_P;
            if (w_push && !w_pop)      r_level <= r_level + ONE_L;
            else if (!w_push && w_pop) r_level <= r_level - ONE_L;
        end
    end

    // FIFO storage; contents are qualified by the level, so no reset needed
    always_ff @(posedge systemClock) begin
        if (w_push) r_mem[r_wptr] <= addressDataIn;
    end

    assign fifoEmptyOut = (r_level == '0);
    assign fifoLevelOut = r_level;
    assign fifoDataOut  = fifoEmptyOut ? 32'd0 : r_mem[r_rptr];

endmodule
